adder_tree_arbiter: RTL and testbench
=====================================

ADDER_TREE_ARBITER -- requirements
Module: adder_tree_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the tree (>=2).
REQ-002 Parameter NUM_INPUT, default 8: operands per request.
REQ-003 Parameter WIDTH_IN, default 16: operand width.
REQ-004 Parameter IS_SIGNED, default 1: 1 = two's-complement sum, 0 = unsigned.
REQ-005 Parameter OUTPUT_DELAY, default 2: adder-tree pipeline depth in cycles (>=0).
REQ-006 Derived WIDTH_OUT = WIDTH_IN + $clog2(NUM_INPUT); ID_W = $clog2(NUM_REQ).
REQ-007 clk  in  1  single clock, rising edge.
REQ-008 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-009 req_valid  in  [NUM_REQ]  requester i offers an operand vector.
REQ-010 req_ready  out  [NUM_REQ]  requester i's vector accepted this cycle.
REQ-011 req_data  in  [NUM_REQ][NUM_INPUT][WIDTH_IN]  operand vectors.
REQ-012 rsp_valid  out  1  rsp_sum/rsp_id valid.
REQ-013 rsp_ready  in  1  consumer accepts response.
REQ-014 rsp_id  out  ID_W  index of requester owning the result.
REQ-015 rsp_sum  out  WIDTH_OUT  full-precision sum.
REQ-016 inflight  out  $clog2(OUTPUT_DELAY+2)+1  accepted-but-not-yet-consumed count.

Function
REQ-017 advance = !rsp_valid || rsp_ready; the whole pipeline (tree ena, tag pipe, output register) moves only when advance=1.
REQ-018 Grant: round-robin, first i with req_valid[i]=1 searching from pointer ptr upward with wrap; at most one req_ready bit high.
REQ-019 req_ready[i] = advance && grant[i]; a transfer occurs when req_valid[i] && req_ready[i].
REQ-020 On transfer from i, ptr <= (i+1) mod NUM_REQ; otherwise ptr holds.
REQ-021 Grant selection is combinational from req_valid and ptr; requesters keep req_valid/req_data stable until ready (not checked by block).
REQ-022 Selected vector drives an instance of the team adder tree with same NUM_INPUT/WIDTH_IN/IS_SIGNED/OUTPUT_DELAY, ena = advance.
REQ-023 Tag pipe of OUTPUT_DELAY stages carries {valid, id} in lock-step with tree registers, same ena; zero stages when OUTPUT_DELAY=0.
REQ-024 Output register: on advance, rsp_valid <= tag valid, rsp_id <= tag id, rsp_sum <= tree dout; total latency transfer->rsp_valid = OUTPUT_DELAY+1 cycles with no backpressure.
REQ-025 Bubbles (no transfer in a cycle) enter the pipe as valid=0; rsp_valid never asserts for a bubble.
REQ-026 Stall: rsp_valid=1 && rsp_ready=0 freezes all stages, rsp_* hold, all req_ready=0.
REQ-027 Sum is exact (no overflow/truncation) per IS_SIGNED extension.
REQ-028 inflight +1 on transfer, -1 on rsp_valid&&rsp_ready, unchanged when both occur same cycle; never exceeds OUTPUT_DELAY+1.
REQ-029 Full throughput: one transfer and one response per cycle sustained while rsp_ready=1.

Reset
REQ-030 rst_n=0 asynchronously clears: rsp_valid=0, rsp_id=0, rsp_sum=0, all tag valids=0, ptr=0, inflight=0; req_ready=0 while in reset.
REQ-031 Reset mid-operation discards all in-flight vectors; no response for them after release.
REQ-032 Tree data registers need no reset; their contents are never exposed while tag valid=0.
REQ-033 First transfer possible in the first cycle after rst_n deasserts.

Structure
REQ-034 Shared package holds width-derivation functions (WIDTH_OUT, ID_W) and the tag struct {valid, id}.
REQ-035 Sub-module rr_arbiter (req vector, ptr, advance -> one-hot grant, grant index) is the one natural sub-module; adder tree is instantiated, not re-implemented.
REQ-036 Target 150-250 lines RTL excluding the adder tree.

Verification
REQ-037 NUM_REQ=4, OUTPUT_DELAY=2, all four valid from cycle 0, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; responses at cycle 3,4,5,6 with ids 0,1,2,3.
REQ-038 Signed, req 2 alone with eight operands 16'h8000 -> rsp_sum = 19'h40000 (-262144), rsp_id=2, 3 cycles later.
REQ-039 Unsigned, eight operands 16'hFFFF -> rsp_sum = 19'h7FFF8; no overflow.
REQ-040 rsp_ready held 0 for 5 cycles with pipe full -> rsp_* stable, req_ready all 0, inflight=3; on release, 3 responses in order on consecutive cycles, none lost or duplicated.
REQ-041 rst_n pulsed low while inflight=2 -> rsp_valid=0 immediately, inflight=0, ptr=0, no stale response afterwards.
REQ-042 OUTPUT_DELAY=0 build, single requester streaming -> latency 1 cycle, one response per cycle, ids correct.

Source files
------------

// File: rtl/adder_tree_arbiter_pkg.sv
// adder_tree_arbiter_pkg: width helpers and the {valid, id} tag carried beside the tree
package adder_tree_arbiter_pkg;
  localparam int MAX_ID_W = 8;
  function automatic int width_out(int width_in, int num_input);
    return width_in + $clog2(num_input);
  endfunction
  function automatic int id_w(int num_req);
    return $clog2(num_req);
  endfunction
  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } tag_t;
endpackage

// File: rtl/adder_tree.sv
// adder_tree: exact sum of NUM_INPUT operands behind OUTPUT_DELAY enabled register stages
module adder_tree
  import adder_tree_arbiter_pkg::*;
#(
  parameter int NUM_INPUT    = 8,
  parameter int WIDTH_IN     = 16,
  parameter int IS_SIGNED    = 1,
  parameter int OUTPUT_DELAY = 2,
  localparam int WIDTH_OUT   = width_out(WIDTH_IN, NUM_INPUT)
)(
  input  logic                                clk,
  input  logic                                ena,
  input  logic [NUM_INPUT-1:0][WIDTH_IN-1:0]  din,
  output logic [WIDTH_OUT-1:0]                dout
);
  logic [WIDTH_OUT-1:0] sum;
  always_comb begin
    sum = '0;
    for (int k = 0; k < NUM_INPUT; k++)
      sum = sum + {{(WIDTH_OUT-WIDTH_IN){IS_SIGNED != 0 && din[k][WIDTH_IN-1]}}, din[k]};
  end
  generate
    if (OUTPUT_DELAY == 0) begin : g_comb
      assign dout = sum;
    end else begin : g_pipe
      // Data stages are unreset; the tag pipe alone decides what is visible.
      logic [WIDTH_OUT-1:0] stage [OUTPUT_DELAY];
      always_ff @(posedge clk) begin
        if (ena) begin
          stage[0] <= sum;
          for (int k = 1; k < OUTPUT_DELAY; k++) stage[k] <= stage[k-1];
        end
      end
      assign dout = stage[OUTPUT_DELAY-1];
    end
  endgenerate
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant to the first requester at or above ptr, wrapping
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
)(
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         advance,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx
);
  logic         found;
  logic [W-1:0] j;
  always_comb begin
    found = 1'b0;
    idx = '0;
    j = '0;
    for (int k = 0; k < N; k++) begin
      j = W'((int'(ptr) + k) % N);
      if (!found && req[j]) begin
        found = 1'b1;
        idx = j;
      end
    end
    grant = (found && advance) ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/adder_tree_arbiter.sv
// adder_tree_arbiter: round-robin sharing of one pipelined adder tree among NUM_REQ requesters
module adder_tree_arbiter
  import adder_tree_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int NUM_INPUT    = 8,
  parameter int WIDTH_IN     = 16,
  parameter int IS_SIGNED    = 1,
  parameter int OUTPUT_DELAY = 2,
  localparam int WIDTH_OUT   = width_out(WIDTH_IN, NUM_INPUT),
  localparam int ID_W        = id_w(NUM_REQ),
  localparam int CNT_W       = $clog2(OUTPUT_DELAY + 2) + 1
)(
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [NUM_REQ-1:0]                            req_valid,
  output logic [NUM_REQ-1:0]                            req_ready,
  input  logic [NUM_REQ-1:0][NUM_INPUT-1:0][WIDTH_IN-1:0] req_data,
  output logic                                          rsp_valid,
  input  logic                                          rsp_ready,
  output logic [ID_W-1:0]                               rsp_id,
  output logic [WIDTH_OUT-1:0]                          rsp_sum,
  output logic [CNT_W-1:0]                              inflight
);
  logic                 advance, xfer, pop;
  logic [NUM_REQ-1:0]   grant;
  logic [ID_W-1:0]      idx, ptr;
  logic [WIDTH_OUT-1:0] tree_dout;
  tag_t                 tag_in, tag_out;
  assign advance = !rsp_valid || rsp_ready;
  assign req_ready = rst_n ? grant : '0;
  assign xfer = |req_ready;
  assign pop = rsp_valid && rsp_ready;
  assign tag_in = '{valid: xfer, id: MAX_ID_W'(idx)};
  rr_arbiter #(.N(NUM_REQ), .W(ID_W)) u_arb (
    .req(req_valid), .ptr(ptr), .advance(advance), .grant(grant), .idx(idx)
  );
  adder_tree #(
    .NUM_INPUT(NUM_INPUT), .WIDTH_IN(WIDTH_IN), .IS_SIGNED(IS_SIGNED), .OUTPUT_DELAY(OUTPUT_DELAY)
  ) u_tree (
    .clk(clk), .ena(advance), .din(req_data[idx]), .dout(tree_dout)
  );
  generate
    if (OUTPUT_DELAY == 0) begin : g_tag_comb
      assign tag_out = tag_in;
    end else begin : g_tag_pipe
      tag_t tag_q [OUTPUT_DELAY];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < OUTPUT_DELAY; k++) tag_q[k] <= '0;
        end else if (advance) begin
          tag_q[0] <= tag_in;
          for (int k = 1; k < OUTPUT_DELAY; k++) tag_q[k] <= tag_q[k-1];
        end
      end
      assign tag_out = tag_q[OUTPUT_DELAY-1];
    end
  endgenerate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_sum <= '0;
      ptr <= '0;
      inflight <= '0;
    end else begin
      if (advance) begin
        rsp_valid <= tag_out.valid;
        rsp_id <= tag_out.id[ID_W-1:0];
        rsp_sum <= tree_dout;
      end
      if (xfer) ptr <= (idx == ID_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
      if (xfer != pop) inflight <= xfer ? inflight + 1'b1 : inflight - 1'b1;
    end
  end
endmodule

// File: tb/tb_adder_tree_arbiter.sv
// tb_adder_tree_arbiter: signed/delay-2 and unsigned/delay-0 builds against a slot-queue model
module tb_adder_tree_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] rv [2];
  logic [3:0][7:0][15:0] rd [2];
  logic rr [2];
  logic [3:0] rdy0, rdy1;
  logic v0, v1;
  logic [1:0] id0, id1;
  logic [18:0] s0, s1;
  logic [2:0] inf0;
  logic [1:0] inf1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;

  adder_tree_arbiter dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv[0]), .req_ready(rdy0), .req_data(rd[0]),
    .rsp_valid(v0), .rsp_ready(rr[0]), .rsp_id(id0), .rsp_sum(s0), .inflight(inf0)
  );
  adder_tree_arbiter #(.IS_SIGNED(0), .OUTPUT_DELAY(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv[1]), .req_ready(rdy1), .req_data(rd[1]),
    .rsp_valid(v1), .rsp_ready(rr[1]), .rsp_id(id1), .rsp_sum(s1), .inflight(inf1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Exact sum of one requester's operands, computed with plain integers.
  function automatic logic [18:0] msum(int u, int r);
    longint s = 0;
    for (int k = 0; k < 8; k++) begin
      longint x = longint'(rd[u][r][k]);
      if (u == 0 && x >= 32768) x -= 65536;
      s += x;
    end
    return s[18:0];
  endfunction

  // Model: unit 0 holds two pipeline slots before its output, unit 1 none.
  int mptr [2];
  int minf [2];
  logic out_v [2];
  int out_id [2];
  logic [18:0] out_s [2];
  logic pv [2];
  int pid [2];
  logic [18:0] ps [2];

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      logic [3:0] a_rdy;
      logic a_v;
      logic [1:0] a_id;
      logic [18:0] a_s;
      int a_inf, g;
      logic adv, pop, nv;
      logic [18:0] ns;
      a_rdy = (u == 0) ? rdy0 : rdy1;
      a_v = (u == 0) ? v0 : v1;
      a_id = (u == 0) ? id0 : id1;
      a_s = (u == 0) ? s0 : s1;
      a_inf = (u == 0) ? int'(inf0) : int'(inf1);
      if (!rst_n) begin
        mptr[u] = 0; minf[u] = 0; out_v[u] = 1'b0; out_id[u] = 0; out_s[u] = '0;
        pv[0] = 1'b0; pv[1] = 1'b0;
        chk("m_rst_valid", 64'(a_v), 64'd0);
        chk("m_rst_ready", 64'(a_rdy), 64'd0);
        chk("m_rst_inflight", 64'(a_inf), 64'd0);
        chk("m_rst_sum", 64'(a_s), 64'd0);
      end else begin
        adv = !out_v[u] || rr[u];
        g = -1;
        for (int k = 0; k < 4; k++) if (g < 0 && rv[u][(mptr[u] + k) % 4]) g = (mptr[u] + k) % 4;
        chk("m_ready", 64'(a_rdy), (adv && g >= 0) ? 64'(1) << g : 64'd0);
        chk("m_valid", 64'(a_v), 64'(out_v[u]));
        chk("m_inflight", 64'(a_inf), 64'(minf[u]));
        if (out_v[u]) begin
          chk("m_id", 64'(a_id), 64'(out_id[u]));
          chk("m_sum", 64'(a_s), 64'(out_s[u]));
        end
        pop = out_v[u] && rr[u];
        if (adv) begin
          nv = g >= 0;
          ns = (g >= 0) ? msum(u, g) : 19'd0;
          if (u == 1) begin
            out_v[u] = nv; out_id[u] = g; out_s[u] = ns;
          end else begin
            out_v[u] = pv[1]; out_id[u] = pid[1]; out_s[u] = ps[1];
            pv[1] = pv[0]; pid[1] = pid[0]; ps[1] = ps[0];
            pv[0] = nv; pid[0] = g; ps[0] = ns;
          end
          if (g >= 0) mptr[u] = (g + 1) % 4;
        end
        minf[u] = minf[u] + ((adv && g >= 0) ? 1 : 0) - (pop ? 1 : 0);
      end
    end
  end

  logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  int exp_id [5] = '{0, 1, 2, 3, 0};
  int drain_id [3] = '{0, 1, 0};

  initial begin
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      rv[u] = '0; rd[u] = '0; rr[u] = 1'b1;
    end
    repeat (3) step();
    // All four requesters valid from the first cycle after reset.
    rst_n = 1'b1;
    for (int r = 0; r < 4; r++) for (int k = 0; k < 8; k++) rd[0][r][k] = 16'(r * 8 + k + 1);
    rv[0] = 4'hF;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c < 5) chk("rr_grant", 64'(rdy0), 64'(exp_g[c]));
      if (c >= 3) begin
        chk("rr_rsp_valid", 64'(v0), 64'd1);
        chk("rr_rsp_id", 64'(id0), 64'(exp_id[c-3]));
      end
      if (c == 3) chk("rr_sum0", 64'(s0), 64'd36);
      step();
      if (c == 4) rv[0] = '0;
    end
    repeat (4) step();
    // Signed minimum operands from requester 2.
    for (int k = 0; k < 8; k++) rd[0][2][k] = 16'h8000;
    rv[0] = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) chk("sgn_grant", 64'(rdy0), 64'b0100);
      if (c == 3) begin
        chk("sgn_valid", 64'(v0), 64'd1);
        chk("sgn_id", 64'(id0), 64'd2);
        chk("sgn_sum", 64'(s0), 64'h40000);
      end
      step();
      if (c == 0) rv[0] = '0;
    end
    // Unsigned build with no tree delay: max operands, then streaming from requester 3.
    for (int k = 0; k < 8; k++) rd[1][0][k] = 16'hFFFF;
    rv[1] = 4'b0001;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("uns_valid", 64'(v1), 64'd1);
        chk("uns_id", 64'(id1), 64'd0);
        chk("uns_sum", 64'(s1), 64'h7FFF8);
      end
      if (c >= 2) begin
        chk("d0_valid", 64'(v1), 64'd1);
        chk("d0_id", 64'(id1), 64'd3);
        chk("d0_sum", 64'(s1), 64'(8 * (c - 1)));
      end
      step();
      if (c == 0) rv[1] = 4'b1000;
      if (c < 4) for (int k = 0; k < 8; k++) rd[1][3][k] = 16'(c + 1);
      if (c == 4) rv[1] = '0;
    end
    repeat (2) step();
    // Backpressure with the pipe full, then release.
    for (int r = 0; r < 2; r++) for (int k = 0; k < 8; k++) rd[0][r][k] = 16'(100 * r + k);
    rv[0] = 4'b0011;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c >= 3 && c <= 7) begin
        chk("stall_valid", 64'(v0), 64'd1);
        chk("stall_id", 64'(id0), 64'd0);
        chk("stall_sum", 64'(s0), 64'd28);
        chk("stall_ready", 64'(rdy0), 64'd0);
        chk("stall_inflight", 64'(inf0), 64'd3);
      end
      if (c >= 8 && c <= 10) begin
        chk("drain_valid", 64'(v0), 64'd1);
        chk("drain_id", 64'(id0), 64'(drain_id[c-8]));
      end
      if (c == 11) chk("drain_done", 64'(v0), 64'd0);
      step();
      if (c == 2) rr[0] = 1'b0;
      if (c == 7) begin
        rr[0] = 1'b1;
        rv[0] = '0;
      end
    end
    // Reset with two vectors in flight.
    rv[0] = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 2) chk("pre_rst_inflight", 64'(inf0), 64'd2);
      step();
      if (c == 1) rv[0] = '0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(v0), 64'd0);
    chk("rst_inflight", 64'(inf0), 64'd0);
    chk("rst_ready", 64'(rdy0), 64'd0);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("no_stale", 64'(v0), 64'd0);
      step();
    end
    rv[0] = 4'hF;
    @(negedge clk);
    chk("ptr_reset", 64'(rdy0), 64'b0001);
    step();
    rv[0] = '0;
    repeat (5) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
